tube_scroller: RTL and testbench

- Game-state producer for the pipe obstacles.
- Generates the `tube_x[2:0]` / `gap_y[2:0]` arrays that the frame renderer reads, and the score.
- Advances all tubes once per video frame and respawns each tube off the right edge with a pseudo-random gap height.
- Emits a score pulse each time a tube passes the bird column.
- Sits between the game controller (start/collision) and the draw path.

---
 rtl/game_pkg.sv | 27 ++
 rtl/lfsr16.sv | 15 +
 rtl/tube_scroller.sv | 130 +++++++++++++
 tb/tb_tube_scroller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants, state encoding and helpers for the pipe obstacles.
// Used by both this block and the frame renderer.
package game_pkg;

    localparam int SCREEN_W   = 1024;
    localparam int TUBE_WIDTH = 120;
    localparam int GAP_HEIGHT = 250;
    localparam int BIRD1_X    = 180;
    localparam int NUM_TUBES  = 3;
    localparam int COORD_W    = 11;
    localparam int SCORE_W    = 10;
    localparam int SCORE_MAX  = 999;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [SCORE_W-1:0] score_t;

    typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

    // Fold a 9-bit random value into [0, gap_range) with one conditional subtract.
    function automatic coord_t gap_from_rand(input logic [8:0] r, input int gap_min,
                                             input int gap_range);
        logic [8:0] red;
        red = (r >= 9'(gap_range)) ? r - 9'(gap_range) : r;
        return coord_t'(gap_min) + coord_t'(red);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running every clock.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (rst) value <= SEED;
        else     value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
    end

endmodule

// File: rtl/tube_scroller.sv
// Pipe obstacle game state: scrolls tubes per frame, respawns with random gaps, counts passes.
// Optional macro TUBE_SCROLLER_SPEEDUP_EN: speed grows by one every 8 points up to SPEED_MAX.
module tube_scroller
    import game_pkg::*;
#(
    parameter int          SPEED     = 4,
    parameter int          SPACING   = 400,
    parameter int          START_X   = SCREEN_W,
    parameter int          GAP_MIN   = 80,
    parameter int          GAP_RANGE = 388,
    parameter int          SCORE_X   = BIRD1_X,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          SPEED_MAX = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             frame_tick,
    input  logic                             start,
    input  logic                             freeze,
    output logic [NUM_TUBES-1:0][COORD_W-1:0] tube_x,
    output logic [NUM_TUBES-1:0][COORD_W-1:0] gap_y,
    output logic                             pass_pulse,
    output logic [SCORE_W-1:0]               score,
    output logic                             running
);

    if (2 * SPACING + START_X >= 2048) begin : g_bad_max_x
        $error("tube_scroller: 2*SPACING+START_X must be below 2048");
    end
    if (SPEED < 1 || SPEED >= SPACING || SPEED_MAX < SPEED) begin : g_bad_speed
        $error("tube_scroller: SPEED must be in 1..SPACING-1 and not above SPEED_MAX");
    end
    if (GAP_RANGE < 256 || GAP_RANGE > 511) begin : g_bad_range
        $error("tube_scroller: GAP_RANGE must be in 256..511");
    end

    state_t                 state, state_next;
    logic                   do_move, do_reload;
    logic [15:0]            lfsr;
    coord_t                 speed;
    coord_t                 new_gap;
    coord_t [NUM_TUBES-1:0] moved_x;
    logic   [NUM_TUBES-1:0] respawn;
    logic   [NUM_TUBES-1:0] pass_hit;
    score_t                 score_inc;
    logic                   unused_lfsr_hi;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:9];
    assign new_gap        = gap_from_rand(lfsr[8:0], GAP_MIN, GAP_RANGE);
    assign score_inc      = score + score_t'(1);

    always_comb begin
        state_next = state;
        do_move    = 1'b0;
        do_reload  = 1'b0;
        case (state)
            IDLE:   if (start) state_next = RUN;
            RUN: begin
                // freeze beats a same-cycle tick: no move on the collision frame
                if (freeze)          state_next = FROZEN;
                else if (frame_tick) do_move    = 1'b1;
            end
            FROZEN: if (start && !freeze) begin
                state_next = RUN;
                do_reload  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    assign running = (state == RUN);

    for (genvar i = 0; i < NUM_TUBES; i++) begin : g_tube
        localparam int PRED = (i + NUM_TUBES - 1) % NUM_TUBES;
        // Respawn hangs off the predecessor's post-move edge so spacing is exact.
        assign respawn[i]  = tube_x[i] < speed;
        assign moved_x[i]  = respawn[i] ? tube_x[PRED] - speed + coord_t'(SPACING)
                                        : tube_x[i] - speed;
        assign pass_hit[i] = ({1'b0, tube_x[i]}  + 12'(TUBE_WIDTH) >  12'(SCORE_X)) &&
                             ({1'b0, moved_x[i]} + 12'(TUBE_WIDTH) <= 12'(SCORE_X));
    end

    always_ff @(posedge clk) begin
        if (rst || do_reload) begin
            for (int i = 0; i < NUM_TUBES; i++) begin
                tube_x[i] <= coord_t'(START_X + i * SPACING);
                gap_y[i]  <= coord_t'(GAP_MIN + i * 128);
            end
            score      <= '0;
            pass_pulse <= 1'b0;
        end else begin
            pass_pulse <= 1'b0;
            if (do_move) begin
                for (int i = 0; i < NUM_TUBES; i++) begin
                    tube_x[i] <= moved_x[i];
                    if (respawn[i]) gap_y[i] <= new_gap;
                end
                if (|pass_hit) begin
                    pass_pulse <= 1'b1;
                    if (score < score_t'(SCORE_MAX)) score <= score_inc;
                end
            end
        end
    end

`ifdef TUBE_SCROLLER_SPEEDUP_EN
    always_ff @(posedge clk) begin
        if (rst || do_reload) begin
            speed <= coord_t'(SPEED);
        end else if (do_move && |pass_hit && score < score_t'(SCORE_MAX) &&
                     score_inc[2:0] == 3'd0 && speed < coord_t'(SPEED_MAX)) begin
            speed <= speed + coord_t'(1);
        end
    end
`else
    assign speed = coord_t'(SPEED);
`endif

endmodule

// File: tb/tb_tube_scroller.sv
// Randomized bench for tube_scroller against a behavioural game model.
module tb_tube_scroller;

    logic             clk = 1'b0;
    logic             rst, frame_tick, start, freeze;
    logic [2:0][10:0] tube_x, gap_y;
    logic             pass_pulse, running;
    logic [9:0]       score;

    int n_chk  = 0;
    int n_pass = 0;

    // behavioural model
    int       m_x[3], m_gap[3], m_score, m_spd;
    bit       m_pass, m_run, m_frz;
    bit [15:0] m_lfsr;

    tube_scroller dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .freeze     (freeze),
        .tube_x     (tube_x),
        .gap_y      (gap_y),
        .pass_pulse (pass_pulse),
        .score      (score),
        .running    (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic bit [15:0] lfsr_adv(input bit [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic model_reload();
        for (int i = 0; i < 3; i++) begin
            m_x[i]   = 1024 + 400 * i;
            m_gap[i] = 80 + 128 * i;
        end
        m_score = 0;
        m_pass  = 0;
        m_spd   = 4;
    endtask

    task automatic model_step(input bit ft, input bit st, input bit fz, input bit r);
        int old[3];
        int nx, rv;
        if (r) begin
            model_reload();
            m_run  = 0;
            m_frz  = 0;
            m_lfsr = 16'hACE1;
            return;
        end
        m_pass = 0;
        if (!m_run && !m_frz) begin
            if (st) m_run = 1;
        end else if (m_run) begin
            if (fz) begin
                m_run = 0;
                m_frz = 1;
            end else if (ft) begin
                old = m_x;
                for (int i = 0; i < 3; i++) begin
                    if (old[i] >= m_spd) nx = old[i] - m_spd;
                    else begin
                        nx = old[(i + 2) % 3] - m_spd + 400;
                        rv = m_lfsr % 512;
                        if (rv >= 388) rv -= 388;
                        m_gap[i] = 80 + rv;
                    end
                    if (old[i] + 120 > 180 && nx + 120 <= 180) m_pass = 1;
                    m_x[i] = nx;
                end
                if (m_pass && m_score < 999) begin
                    m_score++;
`ifdef TUBE_SCROLLER_SPEEDUP_EN
                    if (m_score % 8 == 0 && m_spd < 8) m_spd++;
`endif
                end
            end
        end else if (st && !fz) begin
            model_reload();
            m_frz = 0;
            m_run = 1;
        end
        m_lfsr = lfsr_adv(m_lfsr);
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("tube_x%0d", i), tube_x[i], m_x[i]);
            chk($sformatf("gap_y%0d", i), gap_y[i], m_gap[i]);
        end
        chk("score", score, m_score);
        chk("pass_pulse", pass_pulse, m_pass);
        chk("running", running, m_run);
    endtask

    task automatic cycle(input bit ft, input bit st, input bit fz, input bit r);
        frame_tick = ft;
        start      = st;
        freeze     = fz;
        rst        = r;
        @(posedge clk);
        model_step(ft, st, fz, r);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int saved_x0;
        bit ft, st, fz, r;

        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        chk("rst_x0", tube_x[0], 1024);
        chk("rst_x1", tube_x[1], 1424);
        chk("rst_x2", tube_x[2], 1824);
        chk("rst_g0", gap_y[0], 80);
        chk("rst_g1", gap_y[1], 208);
        chk("rst_g2", gap_y[2], 336);
        chk("rst_score", score, 0);
        chk("rst_running", running, 0);

        repeat (3) cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        chk("idle_x0", tube_x[0], 1024);
        chk("idle_running", running, 0);

        cycle(0, 1, 0, 0);
        chk("start_running", running, 1);
        for (int t = 1; t <= 257; t++) begin
            cycle(1, 0, 0, 0);
            if (t == 1) begin
                chk("t1_x0", tube_x[0], 1020);
                chk("t1_x1", tube_x[1], 1420);
                chk("t1_x2", tube_x[2], 1820);
            end
            if (t == 240 || t == 242) chk("no_pass", pass_pulse, 0);
            if (t == 241) begin
                chk("t241_pass", pass_pulse, 1);
                chk("t241_score", score, 1);
            end
            if (t == 256) chk("t256_x0", tube_x[0], 0);
            if (t == 257) begin
                chk("t257_x0", tube_x[0], 1196);
                chk("t257_x1", tube_x[1], 396);
                chk("t257_x2", tube_x[2], 796);
                chk("t257_gap_rng", int'(gap_y[0] >= 80 && gap_y[0] <= 467), 1);
            end
            repeat ($urandom_range(0, 2)) cycle(0, 0, 0, 0);
        end

        saved_x0 = tube_x[0];
        cycle(1, 1, 1, 0);
        chk("frz_running", running, 0);
        repeat (10) cycle(1, 0, 0, 0);
        chk("frz_x0", tube_x[0], saved_x0);
        chk("frz_score", score, 1);
        cycle(0, 1, 1, 0);
        chk("frz_both_running", running, 0);
        cycle(0, 1, 0, 0);
        chk("reload_x0", tube_x[0], 1024);
        chk("reload_score", score, 0);
        chk("reload_running", running, 1);

        repeat (5) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 1);
        chk("midrun_rst_x0", tube_x[0], 1024);
        chk("midrun_rst_running", running, 0);

        for (int n = 0; n < 4000; n++) begin
            ft = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 15) == 0);
            fz = ($urandom_range(0, 1023) == 0);
            r  = ($urandom_range(0, 1999) == 0);
            cycle(ft, st, fz, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
